// File: rtl/addsub_chunked_multicycle_if.sv
// Operand/result handshake bundle for the chunked multi-cycle add/sub unit.
// The producer/consumer side uses master; the arithmetic unit uses slave.
interface addsub_chunked_multicycle_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  sub_add;
  logic                  carry_in;
  logic [WORD_WIDTH-1:0] A;
  logic [WORD_WIDTH-1:0] B;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] sum;
  logic                  carry_out;
  logic                  overflow;

  modport master (
    output in_valid, sub_add, carry_in, A, B, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, sub_add, carry_in, A, B, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/addsub_chunked_multicycle.sv
// Wide add/subtract computed CHUNK_WIDTH bits per cycle, LS chunk first,
// with the inter-chunk carry held in a register; registered result and flags.
module addsub_chunked_multicycle #(
  parameter int WORD_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  addsub_chunked_multicycle_if.slave bus
);
  localparam int CHUNK_COUNT = WORD_WIDTH / CHUNK_WIDTH;
  localparam int IDX_WIDTH   = (CHUNK_COUNT > 1) ? $clog2(CHUNK_COUNT) : 1;
  // Chunk lookup tables are padded to a power of two so idx never indexes past the array.
  localparam int CHUNK_SLOTS = 1 << IDX_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CHUNK_COUNT - 1);

  if (CHUNK_WIDTH <= 0 || WORD_WIDTH <= 0 || (WORD_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_params
    $error("WORD_WIDTH must be a non-zero multiple of CHUNK_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPUTE,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  a_q, a_d;
  logic [WORD_WIDTH-1:0]  bx_q, bx_d;
  logic                   carry_q, carry_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                   carry_out_q, carry_out_d;
  logic                   overflow_q, overflow_d;
  logic [WORD_WIDTH-1:0]  sum_q;

  logic                   in_ready;
  logic                   accept;
  logic [CHUNK_WIDTH-1:0] a_chunks  [CHUNK_SLOTS];
  logic [CHUNK_WIDTH-1:0] bx_chunks [CHUNK_SLOTS];
  logic [CHUNK_WIDTH:0]   chunk_total;

  // Reset gating keeps a producer from seeing ready while the unit is held in reset.
  assign in_ready = !reset && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;

  genvar gi;
  for (gi = 0; gi < CHUNK_SLOTS; gi++) begin : g_slot
    if (gi < CHUNK_COUNT) begin : g_used
      assign a_chunks[gi]  = a_q[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
      assign bx_chunks[gi] = bx_q[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
    end else begin : g_pad
      assign a_chunks[gi]  = '0;
      assign bx_chunks[gi] = '0;
    end
  end

  assign chunk_total = {1'b0, a_chunks[idx_q]}
                     + {1'b0, bx_chunks[idx_q]}
                     + {{CHUNK_WIDTH{1'b0}}, carry_q};

  // Each result chunk is its own register, written only on its COMPUTE cycle.
  for (gi = 0; gi < CHUNK_COUNT; gi++) begin : g_sum
    logic [CHUNK_WIDTH-1:0] sum_chunk_q, sum_chunk_d;

    always_comb begin
      sum_chunk_d = sum_chunk_q;
      if ((state_q == ST_COMPUTE) && (idx_q == IDX_WIDTH'(gi))) begin
        sum_chunk_d = chunk_total[CHUNK_WIDTH-1:0];
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sum_chunk_q <= '0;
      end else begin
        sum_chunk_q <= sum_chunk_d;
      end
    end

    assign sum_q[gi*CHUNK_WIDTH +: CHUNK_WIDTH] = sum_chunk_q;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    bx_d        = bx_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    case (state_q)
      ST_COMPUTE: begin
        carry_d = chunk_total[CHUNK_WIDTH];
        if (idx_q == LAST_IDX) begin
          state_d     = ST_DONE;
          idx_d       = '0;
          carry_out_d = chunk_total[CHUNK_WIDTH];
          overflow_d  = (a_q[WORD_WIDTH-1] == bx_q[WORD_WIDTH-1])
                      && (chunk_total[CHUNK_WIDTH-1] != a_q[WORD_WIDTH-1]);
        end else begin
          idx_d = idx_q + IDX_WIDTH'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready && !bus.in_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
      end
    endcase

    // Accept overrides the DONE exit so back-to-back operations skip IDLE.
    if (accept) begin
      state_d = ST_COMPUTE;
      a_d     = bus.A;
      bx_d    = bus.sub_add ? ~bus.B : bus.B;
      carry_d = bus.carry_in;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      bx_q        <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      bx_q        <= bx_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
endmodule
